// File: rtl/trap_pkg.sv
// trap_pkg: cause codes, CSR bit positions, FSM states and mstatus helpers for trap_ctrl
package trap_pkg;
    localparam logic [3:0] CAUSE_INST_MISALIGNED  = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INST     = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] CAUSE_MSI              = 4'd3;
    localparam logic [3:0] CAUSE_MTI              = 4'd7;
    localparam logic [3:0] CAUSE_MEI              = 4'd11;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;
    typedef enum logic [1:0] {IDLE, ENTER, RET, REDIRECT} state_t;
    function automatic logic [31:0] entry_mstatus(input logic [31:0] s);
        entry_mstatus = s;
        entry_mstatus[MSTATUS_MPIE] = s[MSTATUS_MIE];
        entry_mstatus[MSTATUS_MIE] = 1'b0;
        entry_mstatus[MSTATUS_MPP_LO +: 2] = 2'b11;
    endfunction
    function automatic logic [31:0] ret_mstatus(input logic [31:0] s);
        ret_mstatus = s;
        ret_mstatus[MSTATUS_MIE] = s[MSTATUS_MPIE];
        ret_mstatus[MSTATUS_MPIE] = 1'b1;
        ret_mstatus[MSTATUS_MPP_LO +: 2] = 2'b11;
    endfunction
endpackage

// File: rtl/irq_sync.sv
// irq_sync: multi-flop synchronisers for the interrupt lines, assembled into an mip vector
module irq_sync
    import trap_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    input  logic        sw_irq_i,
    output logic [31:0] mip_o
);
    logic [SYNC_STAGES-1:0] ext_q, tim_q, sw_q;
    // Shift each asynchronous line through its synchroniser chain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ext_q <= '0;
            tim_q <= '0;
            sw_q  <= '0;
        end else begin
            ext_q <= {ext_q[SYNC_STAGES-2:0], ext_irq_i};
            tim_q <= {tim_q[SYNC_STAGES-2:0], timer_irq_i};
            sw_q  <= {sw_q[SYNC_STAGES-2:0], sw_irq_i};
        end
    end
    // Place the synchronised lines at their mip bit positions
    always_comb begin
        mip_o = '0;
        mip_o[MIP_MEIP] = ext_q[SYNC_STAGES-1];
        mip_o[MIP_MTIP] = tim_q[SYNC_STAGES-1];
        mip_o[MIP_MSIP] = sw_q[SYNC_STAGES-1];
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage trap entry/return sequencer driving the CSR exception-write port
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] bad_addr_i,
    input  logic            e_inst_misaligned_i,
    input  logic            e_illegal_inst_i,
    input  logic            e_illegal_inst_csr_i,
    input  logic            e_ebreak_i,
    input  logic            e_ecall_i,
    input  logic            e_load_misaligned_i,
    input  logic            e_store_misaligned_i,
    input  logic            is_mret_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mcause_i,
    input  logic [XLEN-1:0] mtval_i,
    input  logic            ext_irq_i,
    input  logic            timer_irq_i,
    input  logic            sw_irq_i,
    input  logic            trap_ack_i,
    output logic            we_exc_o,
    output logic            is_int_o,
    output logic [XLEN-1:0] mcause_d_o,
    output logic [XLEN-1:0] mepc_d_o,
    output logic [XLEN-1:0] mtval_d_o,
    output logic [XLEN-1:0] mstatus_d_o,
    output logic [XLEN-1:0] mip_d_o,
    output logic            sel_exc_nret_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            redirect_o
);
    state_t state, state_n;
    logic [XLEN-1:0] mip, pend, exc_tval, mcause_q, mepc_q, mtval_q, mstatus_q;
    logic [3:0] irq_code, exc_code;
    logic irq, illegal, exc, idle_ev, take_trap, take_ret, int_q, ret_q;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .ext_irq_i(ext_irq_i),
        .timer_irq_i(timer_irq_i),
        .sw_irq_i(sw_irq_i),
        .mip_o(mip)
    );

    assign pend      = mie_i & mip & {XLEN{mstatus_i[MSTATUS_MIE]}};
    assign irq       = |pend;
    assign irq_code  = pend[MIP_MEIP] ? CAUSE_MEI : pend[MIP_MSIP] ? CAUSE_MSI : CAUSE_MTI;
    assign illegal   = e_illegal_inst_i | e_illegal_inst_csr_i;
    assign exc       = e_ebreak_i | e_inst_misaligned_i | illegal | e_ecall_i | e_store_misaligned_i | e_load_misaligned_i;
    assign exc_code  = e_ebreak_i ? CAUSE_BREAKPOINT : e_inst_misaligned_i ? CAUSE_INST_MISALIGNED :
                       illegal ? CAUSE_ILLEGAL_INST : e_ecall_i ? CAUSE_ECALL_M :
                       e_store_misaligned_i ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
    assign exc_tval  = e_ebreak_i ? pc_i : e_inst_misaligned_i ? bad_addr_i : illegal ? inst_i :
                       e_ecall_i ? '0 : bad_addr_i;
    assign idle_ev   = state == IDLE && valid_i && !rst_i;
    assign take_trap = idle_ev && (irq || exc);
    assign take_ret  = idle_ev && is_mret_i && !irq && !exc;
    assign mcause_d_o  = mcause_q;
    assign mepc_d_o    = mepc_q;
    assign mtval_d_o   = mtval_q;
    assign mstatus_d_o = mstatus_q;
    assign mip_d_o     = mip;

    // State register plus the CSR next-value record captured on the event cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            mcause_q  <= '0;
            mepc_q    <= '0;
            mtval_q   <= '0;
            mstatus_q <= '0;
            int_q     <= 1'b0;
            ret_q     <= 1'b0;
        end else begin
            state <= state_n;
            if (take_trap) begin
                mcause_q  <= irq ? {1'b1, {(XLEN-5){1'b0}}, irq_code} : {{(XLEN-4){1'b0}}, exc_code};
                mepc_q    <= pc_i;
                mtval_q   <= irq ? '0 : exc_tval;
                mstatus_q <= entry_mstatus(mstatus_i);
                int_q     <= irq;
                ret_q     <= 1'b0;
            end else if (take_ret) begin
                mcause_q  <= mcause_i;
                mepc_q    <= mepc_i;
                mtval_q   <= mtval_i;
                mstatus_q <= ret_mstatus(mstatus_i);
                int_q     <= 1'b0;
                ret_q     <= 1'b1;
            end
        end
    end

    // Next state and pipeline/CSR strobes
    always_comb begin
        state_n = state == IDLE ? (take_trap ? ENTER : take_ret ? RET : IDLE) :
                  state == REDIRECT ? (trap_ack_i ? IDLE : REDIRECT) : REDIRECT;
        we_exc_o       = state == ENTER || state == RET;
        is_int_o       = state == ENTER && int_q;
        sel_exc_nret_o = state != IDLE && ret_q;
        stall_o        = state != IDLE || take_trap || take_ret;
        flush_o        = state == REDIRECT;
        redirect_o     = state == REDIRECT;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/exception controller that drives the machine CSR file's exception-write port: we_exc, is_int, mcause/mepc/mtval/mstatus/mip next values and sel_exc_nret.
- Sits at the commit stage. Collects synchronous exception flags, including the CSR file's illegal-CSR flag, plus synchronised external/timer/software interrupts and MRET.
- Sequences trap entry and return, then stalls, flushes and redirects the pipeline to the CSR file's exc_ret_addr (mtvec on entry, mepc on return).

Parameters:
- SYNC_STAGES, 2, flops in each interrupt synchroniser (>=2)
- XLEN, 32, data width (only 32 supported)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  commit-stage instruction valid
- pc_i  in  32  commit-stage PC
- inst_i  in  32  commit-stage instruction word
- bad_addr_i  in  32  faulting data/fetch address
- e_inst_misaligned_i, e_illegal_inst_i, e_illegal_inst_csr_i, e_ebreak_i, e_ecall_i, e_load_misaligned_i, e_store_misaligned_i  in  1 each  exception flags (qualified by valid_i)
- is_mret_i  in  1  MRET at commit
- mstatus_i, mie_i, mepc_i, mcause_i, mtval_i  in  32 each  current CSR values
- ext_irq_i, timer_irq_i, sw_irq_i  in  1 each  asynchronous interrupt lines
- trap_ack_i  in  1  front end accepted redirect
- we_exc_o  out  1  CSR exception write strobe
- is_int_o  out  1  interrupt-trap strobe (CSR writes mcause, mip)
- mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o  out  32 each  CSR next values
- sel_exc_nret_o  out  1  1 selects mepc (return), 0 selects mtvec (entry)
- stall_o, flush_o, redirect_o  out  1 each  pipeline control

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; synchronisers clear. Reset in any state aborts the operation the same cycle.
- Interrupt sync: each line passes through SYNC_STAGES flops.
- mip_d_o bit layout: bit11 = MEIP, bit7 = MTIP, bit3 = MSIP; all other bits 0. Updated every cycle.
- Interrupt pending: mstatus_i[3] & mie_i[n] & mip[n]. Priority MEI(11) > MSI(3) > MTI(7). Interrupt mcause = {1'b1, 27'b0, code}.
- Exception priority and cause:
  - ebreak 3
  - inst misaligned 0
  - illegal (either flag) 2
  - ecall 11
  - store misaligned 6
  - load misaligned 4
- Event selection in IDLE with valid_i: interrupt > exception > MRET. Events in any other state are ignored.
- FSM states IDLE, ENTER, RET, REDIRECT. All d-outputs are registered and held constant from the ENTER/RET cycle until return to IDLE.
- IDLE -> ENTER on interrupt or exception (cycle N). stall_o rises combinationally in cycle N.
- ENTER (cycle N+1): we_exc_o = 1 for one cycle; is_int_o = 1 iff interrupt; sel_exc_nret_o = 0.
  - mepc_d = pc_i.
  - mtval_d: inst_i for illegal; bad_addr_i for misaligned; pc_i for ebreak; 0 otherwise.
  - mstatus_d = mstatus_i with MPIE(7) = MIE(3), MIE = 0, MPP[12:11] = 2'b11.
- IDLE -> RET on MRET with no exception/interrupt. In RET: we_exc_o = 1 for one cycle; sel_exc_nret_o = 1.
  - mepc_d, mcause_d, mtval_d echo mepc_i, mcause_i, mtval_i, so only mstatus changes.
  - mstatus_d: MIE = MPIE, MPIE = 1, MPP = 2'b11.
- ENTER/RET -> REDIRECT: redirect_o, flush_o and stall_o high; sel_exc_nret_o held. Leave to IDLE on the cycle after trap_ack_i is seen.
- trap_ack_i already high on the first REDIRECT cycle: one-cycle REDIRECT.
- Latency: event in cycle N -> we_exc_o at N+1 -> redirect_o from N+2.
- MRET flagged illegal: exception taken. MRET plus interrupt in the same cycle: interrupt taken, mepc = MRET PC.

Decomposition:
- Package trap_pkg holds:
  - cause codes (CAUSE_*)
  - mstatus bit positions (MSTATUS_MIE = 3, MSTATUS_MPIE = 7, MSTATUS_MPP_LO = 11)
  - mip bit positions
  - FSM state encodings
- Sub-module irq_sync: per-line SYNC_STAGES synchroniser plus mip vector assembly.

Test Plan:
- Illegal inst 0x0000_0000 at pc 0x100, mstatus = 0x8 -> we_exc_o at N+1 with mcause 2, mepc 0x100, mtval 0x0, mstatus_d 0x1880; redirect_o from N+2 until ack.
- timer_irq_i high, mie = 0x80, mstatus = 0x8, pc 0x200 -> after sync, is_int_o = 1, mcause 0x8000_0007, mip_d 0x80, mepc 0x200.
- MRET with mstatus = 0x1880, mepc_i 0x104 -> we_exc_o, sel_exc_nret_o = 1, mstatus_d 0x1888, mepc_d 0x104 unchanged.
- ecall + load misaligned (bad_addr 0x3) same cycle -> mcause 11, mtval 0; ext and sw irq together with both enabled -> mcause 0x8000_000B.
- Interrupt pending with mstatus.MIE = 0 -> no trap; exception during REDIRECT ignored; rst_i during REDIRECT -> next cycle all outputs 0, IDLE.
- trap_ack_i withheld 5 cycles -> redirect_o, flush_o, stall_o held for 5 cycles; d-outputs stable throughout.
